// File: rtl/dump_pkg.sv
// dump_pkg: shared types and constants for the memory dumper.
package dump_pkg;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } dump_state_e;

    // Output buffer depth and the width of its occupancy count.
    localparam int unsigned FifoDepth = 2;
    localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

    // Byte distance between consecutive dumped words.
    localparam int unsigned AddrStride = 4;

endpackage

// File: rtl/dump_fifo.sv
// dump_fifo: two-entry first-word-fall-through buffer with occupancy count.
// The head entry always sits in head_q so the output needs no read mux.
module dump_fifo
    import dump_pkg::*;
#(
    parameter int unsigned Width = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic                pop_i,
    output logic                valid_o,
    output logic [Width-1:0]    rdata_o,
    output logic [FifoCntW-1:0] count_o
);

    logic [Width-1:0]    head_q, head_d;
    logic [Width-1:0]    tail_q, tail_d;
    logic [FifoCntW-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A full buffer can still take a word when the head leaves this cycle.
    assign do_push = push_i && ((count_q != FifoCntW'(FifoDepth)) || do_pop);

    // Next-state for storage and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10: begin
                if (count_q == '0) begin
                    head_d = wdata_i;
                end else begin
                    tail_d = wdata_i;
                end
                count_d = count_q + FifoCntW'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - FifoCntW'(1);
            end
            2'b11: begin
                if (count_q == FifoCntW'(1)) begin
                    head_d = wdata_i;
                end else begin
                    head_d = tail_q;
                    tail_d = wdata_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/mem_dumper.sv
// mem_dumper: reads dump_count words starting at dump_base and streams each
// {address, data} pair out on a valid/ready port in increasing address order.
// Defining MEM_DUMPER_CHECKSUM_EN adds a dump_checksum output holding the
// wrapping sum of the words transferred in the current dump.
module mem_dumper
    import dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [CNT_W-1:0]  dump_count,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
`ifdef MEM_DUMPER_CHECKSUM_EN
    output logic [DATA_W-1:0] dump_checksum,
`endif
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned OccW   = FifoCntW + 1;
    localparam int unsigned EntryW = ADDR_W + DATA_W;

    dump_state_e         state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    rem_q;
    logic                busy_q;
    logic                done_q;
    logic                infl_q;
    logic [ADDR_W-1:0]   infl_addr_q;

    logic                accept;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_valid;
    logic [EntryW-1:0]   fifo_wdata;
    logic [EntryW-1:0]   fifo_rdata;
    logic [FifoCntW-1:0] fifo_cnt;
    logic [OccW-1:0]     occ_next;

    assign accept     = (state_q == StIdle) && dump_start;
    assign fifo_push  = infl_q;
    assign fifo_pop   = fifo_valid && out_ready;
    assign fifo_wdata = {infl_addr_q, mem_rdata};

    // Buffer occupancy after this cycle's push and pop. A read issued now
    // lands next cycle, so it is safe whenever this stays below the depth.
    // Crediting the pop here is what allows one word per cycle.
    assign occ_next = OccW'(fifo_cnt) + OccW'(infl_q) - OccW'(fifo_pop);

    // Combinational so the read decision can use this cycle's out_ready.
    assign mem_re = (state_q == StRead) && (occ_next < OccW'(FifoDepth));

    // Dump sequencer: accepts requests, walks the address range, waits for drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dump_start) begin
                        if (dump_count != '0) begin
                            addr_q  <= dump_base;
                            rem_q   <= dump_count;
                            busy_q  <= 1'b1;
                            state_q <= StRead;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StRead: begin
                    if (mem_re) begin
                        // Wraps naturally modulo 2^ADDR_W.
                        addr_q <= addr_q + ADDR_W'(AddrStride);
                        rem_q  <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // No reads issue here, so empty-after-this-cycle means finished.
                    if (occ_next == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Track the single read in flight and the address its data belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            infl_q <= mem_re;
            if (mem_re) begin
                infl_addr_q <= addr_q;
            end
        end
    end

    dump_fifo #(
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt)
    );

`ifdef MEM_DUMPER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Wrapping sum of words handed to the consumer since the dump was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (fifo_pop) begin
            csum_q <= csum_q + out_data;
        end
    end

    assign dump_checksum = csum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign dump_busy = busy_q;
    assign dump_done = done_q;
    assign mem_raddr = addr_q;
    assign out_valid = fifo_valid;
    assign out_addr  = fifo_rdata[EntryW-1:DATA_W];
    assign out_data  = fifo_rdata[DATA_W-1:0];

endmodule
